// File: rtl/multistep_lif_encoder.sv
// rtl/multistep_lif_encoder.sv - TIME_STEPS-stage pipelined LIF spike encoder with backpressure and frame counting
// Optional tau=2 membrane leak is built in when MULTISTEP_LIF_LEAK_EN is defined.

module multistep_lif_encoder #(
    parameter int DATA_W     = 24,
    parameter int TIME_STEPS = 4,
    parameter int FRAME_LEN  = 1024,
    parameter int CNT_W      = $clog2(FRAME_LEN)
) (
    input  logic                     s_clk,
    input  logic                     s_rst,
    input  logic                     i_clear,
    input  logic signed [DATA_W-1:0] i_threshold,
    input  logic signed [DATA_W-1:0] i_delta,
    input  logic                     i_delta_valid,
    output logic                     o_delta_ready,
    output logic [TIME_STEPS-1:0]    o_spikes,
    output logic                     o_spikes_valid,
    input  logic                     i_spikes_ready,
    output logic                     o_frame_done
);

    // A single-vector frame gives CNT_W = 0; keep at least one counter bit.
    localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
    localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W:0] s);
        logic signed [DATA_W-1:0] r;
        if (s[DATA_W] != s[DATA_W-1]) r = s[DATA_W] ? S_MIN : S_MAX;
        else                          r = s[DATA_W-1:0];
        return r;
    endfunction

    function automatic logic signed [DATA_W-1:0] charge(input logic signed [DATA_W-1:0] vp,
                                                        input logic signed [DATA_W-1:0] x);
`ifdef MULTISTEP_LIF_LEAK_EN
        logic signed [DATA_W-1:0] d;
        logic signed [DATA_W:0]   s;
        d = sat({x[DATA_W-1], x} - {vp[DATA_W-1], vp});
        // vp + (d >>> 1) always lies between vp and x, so it cannot overflow.
        s = {vp[DATA_W-1], vp} + {d[DATA_W-1], d[DATA_W-1], d[DATA_W-1:1]};
        return s[DATA_W-1:0];
`else
        return sat({vp[DATA_W-1], vp} + {x[DATA_W-1], x});
`endif
    endfunction

    logic                     valid_q [TIME_STEPS];
    logic                     valid_d [TIME_STEPS];
    logic signed [DATA_W-1:0] v_q     [TIME_STEPS];
    logic signed [DATA_W-1:0] v_d     [TIME_STEPS];
    logic signed [DATA_W-1:0] x_q     [TIME_STEPS];
    logic signed [DATA_W-1:0] x_d     [TIME_STEPS];
    logic [TIME_STEPS-1:0]    hist_q  [TIME_STEPS];
    logic [TIME_STEPS-1:0]    hist_d  [TIME_STEPS];
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     done_q, done_d;

    logic                     vld_in  [TIME_STEPS];
    logic signed [DATA_W-1:0] v_in    [TIME_STEPS];
    logic signed [DATA_W-1:0] x_in    [TIME_STEPS];
    logic [TIME_STEPS-1:0]    h_in    [TIME_STEPS];
    logic signed [DATA_W-1:0] v_chg   [TIME_STEPS];
    logic                     fire    [TIME_STEPS];
    logic signed [DATA_W-1:0] v_post  [TIME_STEPS];
    logic [TIME_STEPS-1:0]    h_new   [TIME_STEPS];

    logic en, accept, out_hs;

    assign en             = ~valid_q[TIME_STEPS-1] | i_spikes_ready;
    assign o_delta_ready  = en & ~i_clear;
    assign accept         = i_delta_valid & o_delta_ready;
    assign out_hs         = valid_q[TIME_STEPS-1] & i_spikes_ready;
    assign o_spikes       = hist_q[TIME_STEPS-1];
    assign o_spikes_valid = valid_q[TIME_STEPS-1];
    assign o_frame_done   = done_q;

    always_comb begin
        vld_in[0] = accept;
        v_in[0]   = '0;
        x_in[0]   = i_delta;
        h_in[0]   = '0;
        for (int t = 1; t < TIME_STEPS; t++) begin
            vld_in[t] = valid_q[t-1];
            v_in[t]   = v_q[t-1];
            x_in[t]   = x_q[t-1];
            h_in[t]   = hist_q[t-1];
        end
    end

    always_comb begin
        for (int t = 0; t < TIME_STEPS; t++) begin
            v_chg[t]    = charge(v_in[t], x_in[t]);
            fire[t]     = (v_chg[t] >= i_threshold);
            v_post[t]   = fire[t] ? '0 : v_chg[t];
            h_new[t]    = h_in[t];
            h_new[t][t] = fire[t];
        end
    end

    always_comb begin
        valid_d = valid_q;
        v_d     = v_q;
        x_d     = x_q;
        hist_d  = hist_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (i_clear) begin
            for (int t = 0; t < TIME_STEPS; t++) begin
                valid_d[t] = 1'b0;
                v_d[t]     = '0;
                x_d[t]     = '0;
                hist_d[t]  = '0;
            end
            cnt_d = '0;
        end else begin
            if (en) begin
                // Bubbles carry zeroed data so o_spikes reads 0 whenever it is not valid.
                for (int t = 0; t < TIME_STEPS; t++) begin
                    valid_d[t] = vld_in[t];
                    v_d[t]     = vld_in[t] ? v_post[t] : '0;
                    x_d[t]     = vld_in[t] ? x_in[t]   : '0;
                    hist_d[t]  = vld_in[t] ? h_new[t]  : '0;
                end
            end
            if (out_hs) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            for (int t = 0; t < TIME_STEPS; t++) begin
                valid_q[t] <= 1'b0;
                v_q[t]     <= '0;
                x_q[t]     <= '0;
                hist_q[t]  <= '0;
            end
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            v_q     <= v_d;
            x_q     <= x_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_multistep_lif_encoder.sv
// tb/tb_multistep_lif_encoder.sv - scoreboard bench for multistep_lif_encoder (T=4, FRAME_LEN=4)

module tb_multistep_lif_encoder;

    localparam int DW = 24;
    localparam int T  = 4;
    localparam int FL = 4;

    logic                 s_clk = 1'b0;
    logic                 s_rst;
    logic                 i_clear;
    logic signed [DW-1:0] i_threshold;
    logic signed [DW-1:0] i_delta;
    logic                 i_delta_valid;
    logic                 o_delta_ready;
    logic [T-1:0]         o_spikes;
    logic                 o_spikes_valid;
    logic                 i_spikes_ready;
    logic                 o_frame_done;

    multistep_lif_encoder #(.DATA_W(DW), .TIME_STEPS(T), .FRAME_LEN(FL)) dut (
        .s_clk(s_clk), .s_rst(s_rst), .i_clear(i_clear), .i_threshold(i_threshold),
        .i_delta(i_delta), .i_delta_valid(i_delta_valid), .o_delta_ready(o_delta_ready),
        .o_spikes(o_spikes), .o_spikes_valid(o_spikes_valid), .i_spikes_ready(i_spikes_ready),
        .o_frame_done(o_frame_done)
    );

    always #5 s_clk = ~s_clk;

    int           n_cmp = 0;
    int           n_fail = 0;
    logic [T-1:0] sb[$];
    int           f_cnt = 0;
    bit           exp_done = 1'b0;
    int           done_seen = 0;
    int           hs_seen = 0;

    function automatic longint clamp(input longint v);
        longint mx = (64'sd1 <<< (DW-1)) - 1;
        longint mn = -(64'sd1 <<< (DW-1));
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    function automatic logic [T-1:0] exp_vec(input longint d, input longint thr);
        longint       v = 0;
        logic [T-1:0] r = '0;
        for (int t = 0; t < T; t++) begin
`ifdef MULTISTEP_LIF_LEAK_EN
            longint df = clamp(d - v);
            v = v + (df >>> 1);
`else
            v = clamp(v + d);
`endif
            if (v >= thr) begin
                r[t] = 1'b1;
                v    = 0;
            end
        end
        return r;
    endfunction

    // Observation point: inputs are stable, next rising edge not yet reached.
    always @(negedge s_clk) begin
        logic want;
        logic [T-1:0] e;
        #3;
        want = s_rst ? 1'b0 : exp_done;
        n_cmp++;
        if (o_frame_done !== want) begin
            n_fail++;
            $display("FAIL frame_done t=%0t got %b want %b", $time, o_frame_done, want);
        end
        if (o_frame_done === 1'b1) done_seen++;
        exp_done = 1'b0;
        if (s_rst || i_clear) begin
            f_cnt = 0;
        end else if (o_spikes_valid && i_spikes_ready) begin
            hs_seen++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_vector t=%0t got %b want none", $time, o_spikes);
            end else begin
                e = sb.pop_front();
                if (o_spikes !== e) begin
                    n_fail++;
                    $display("FAIL spikes t=%0t got %b want %b", $time, o_spikes, e);
                end
            end
            f_cnt++;
            if (f_cnt == FL) begin
                f_cnt    = 0;
                exp_done = 1'b1;
            end
        end
    end

    task automatic send(input logic signed [DW-1:0] d, input logic [T-1:0] e);
        int tries = 0;
        @(negedge s_clk);
        #1;
        i_delta       = d;
        i_delta_valid = 1'b1;
        #2;
        while (o_delta_ready !== 1'b1) begin
            tries++;
            if (tries > 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout got ready=%b want 1", o_delta_ready);
                i_delta_valid = 1'b0;
                return;
            end
            @(negedge s_clk);
            #3;
        end
        sb.push_back(e);
        @(posedge s_clk);
        #1;
        i_delta_valid = 1'b0;
    endtask

    task automatic send_model(input logic signed [DW-1:0] d);
        send(d, exp_vec(d, i_threshold));
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || o_spikes_valid) && n < 100) begin
            @(negedge s_clk);
            #4;
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        s_rst = 1'b1; i_clear = 1'b0; i_delta = '0; i_delta_valid = 1'b0;
        i_spikes_ready = 1'b1; i_threshold = 24'sd8;
        repeat (3) @(posedge s_clk);
        @(negedge s_clk);
        #3;
        n_cmp += 3;
        if (o_spikes_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", o_spikes_valid); end
        if (o_spikes !== '0) begin n_fail++; $display("FAIL rst_spikes got %b want 0", o_spikes); end
        if (o_delta_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", o_delta_ready); end
        #2;
        s_rst = 1'b0;
    endtask

    task automatic test_latency();
        int k = 0;
`ifdef MULTISTEP_LIF_LEAK_EN
        send(24'sd8, 4'b0000);
`else
        send(24'sd8, 4'b1111);
`endif
        forever begin
            @(negedge s_clk);
            #3;
            if (o_spikes_valid === 1'b1 || k > 20) break;
            k++;
        end
        n_cmp++;
        if (k != T - 1) begin n_fail++; $display("FAIL latency got %0d want %0d", k, T - 1); end
        drain();
    endtask

    task automatic test_directed();
`ifdef MULTISTEP_LIF_LEAK_EN
        send(24'sd16, 4'b1111);
        send(24'sd8, 4'b0000);
`else
        send(24'sd4, 4'b1010);
        send(-24'sd5, 4'b0000);
        send(24'h7FFFFF, 4'b1111);
        send(24'sh800000, 4'b0000);
`endif
        drain();
    endtask

    task automatic test_random();
        int thr_list[3] = '{8, -3, 1000};
        int ti, r;
        logic signed [DW-1:0] d;
        for (int k = 0; k < 3; k++) begin
            drain();
            ti = thr_list[k];
            i_threshold = ti[DW-1:0];
            for (int i = 0; i < 15; i++) begin
                if ($urandom_range(0, 1) == 0) r = int'($urandom_range(0, 40)) - 20;
                else r = int'($urandom);
                d = r[DW-1:0];
                send_model(d);
            end
        end
        drain();
        i_threshold = 24'sd8;
    endtask

    task automatic test_back_to_back();
        int h0 = hs_seen;
        logic [T-1:0] held;
        fork
            for (int i = 0; i < 10; i++) send_model(DW'(i * 3 - 6));
            begin
                repeat (6) @(negedge s_clk);
                #1;
                i_spikes_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    #2;
                    if (c == 0) held = o_spikes;
                    n_cmp += 3;
                    if (o_delta_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b want 0", o_delta_ready); end
                    if (o_spikes_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid got %b want 1", o_spikes_valid); end
                    if (o_spikes !== held) begin n_fail++; $display("FAIL stall_hold got %b want %b", o_spikes, held); end
                    @(negedge s_clk);
                    #1;
                end
                i_spikes_ready = 1'b1;
            end
        join
        drain();
        n_cmp++;
        if (hs_seen - h0 != 10) begin n_fail++; $display("FAIL stream_count got %0d want 10", hs_seen - h0); end
    endtask

    task automatic pulse_clear();
        @(negedge s_clk);
        #1;
        i_clear = 1'b1;
        #2;
        n_cmp++;
        if (o_delta_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready got %b want 0", o_delta_ready); end
        @(negedge s_clk);
        #1;
        i_clear = 1'b0;
    endtask

    task automatic test_frame();
        int d0;
        pulse_clear();
        d0 = done_seen;
        for (int i = 0; i < 9; i++) send_model(DW'(i + 1));
        drain();
        n_cmp++;
        if (done_seen - d0 != 2) begin n_fail++; $display("FAIL frame_pulses got %0d want 2", done_seen - d0); end
        for (int i = 0; i < 3; i++) send_model(24'sd8);
        drain();
        n_cmp++;
        if (done_seen - d0 != 3) begin n_fail++; $display("FAIL frame_resume got %0d want 3", done_seen - d0); end
    endtask

    task automatic test_clear();
        int d0;
        bit seen = 1'b0;
        send_model(24'sd8);
        send_model(24'sd8);
        drain();
        for (int i = 0; i < 3; i++) send_model(24'sd4);
        pulse_clear();
        sb.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge s_clk);
            #4;
            if (o_spikes_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_fail++; $display("FAIL clear_flush got valid=1 want 0"); end
        d0 = done_seen;
        for (int i = 0; i < 4; i++) send_model(24'sd8);
        drain();
        n_cmp++;
        if (done_seen - d0 != 1) begin n_fail++; $display("FAIL clear_frame got %0d want 1", done_seen - d0); end
    endtask

    task automatic test_rst_mid();
        i_spikes_ready = 1'b0;
        for (int i = 0; i < T; i++) send(24'sd8, 4'b1111);
        @(negedge s_clk);
        #3;
        n_cmp++;
        if (o_spikes_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_full got %b want 1", o_spikes_valid); end
        @(negedge s_clk);
        #1;
        s_rst = 1'b1;
        #1;
        n_cmp += 3;
        if (o_spikes_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", o_spikes_valid); end
        if (o_spikes !== '0) begin n_fail++; $display("FAIL rst_mid_spikes got %b want 0", o_spikes); end
        if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %b want 0", o_frame_done); end
        sb.delete();
        @(negedge s_clk);
        #1;
        s_rst = 1'b0;
        i_spikes_ready = 1'b1;
        send_model(24'sd4);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_random();
        test_back_to_back();
        test_frame();
        test_clear();
        test_rst_mid();
        repeat (3) @(posedge s_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
